// File: rtl/idct_level_shift.sv
// idct_level_shift: separable 8x8 inverse DCT (row pass, then column pass) with +128 level shift,
// clamp to 0..255, and a held output block under valid/ready handshaking.
module idct_level_shift #(
  parameter int CH = 3,
  parameter int COEF_FRAC = 12,
  parameter int INT_FRAC = 3,
  parameter int TMP_W = 18,
  localparam int CW = $clog2(CH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [11:0]  blockIn [8][8],
  input  logic [CW-1:0]       chIn,
  input  logic                valid_in,
  output logic                ready_in,
  output logic [7:0]          blockOut [8][8],
  output logic [CW-1:0]       chOut,
  output logic                valid_out,
  input  logic                ready_out
);
  localparam int RSH = COEF_FRAC - INT_FRAC;
  localparam int CSH = COEF_FRAC + INT_FRAC;
  typedef enum logic [1:0] {IDLE, ROW, COL, OUT} state_t;
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic signed [11:0] blk_q [8][8];
  logic signed [11:0] blk_d [8][8];
  logic signed [TMP_W-1:0] tmp_q [8][8];
  logic signed [TMP_W-1:0] tmp_d [8][8];
  logic [7:0] pix_q [8][8];
  logic [7:0] pix_d [8][8];
  logic [CW-1:0] ch_q, ch_d, chout_q, chout_d;
  logic signed [27:0] racc;
  logic signed [33:0] cacc, cs;
  logic accept;
  // Cosine table C[x][u] folded from the quarter-wave magnitudes 2048*cos(k*pi/16).
  function automatic logic signed [12:0] cosv(input int x, input int u);
    int m;
    logic signed [12:0] b;
    m = ((2 * x + 1) * u) % 32;
    m = m > 16 ? 32 - m : m;
    case (m > 8 ? 16 - m : m)
      1: b = 13'sd2009;
      2: b = 13'sd1892;
      3: b = 13'sd1703;
      4: b = 13'sd1448;
      5: b = 13'sd1138;
      6: b = 13'sd784;
      7: b = 13'sd400;
      default: b = 13'sd0;
    endcase
    return u == 0 ? 13'sd1448 : (m > 8 ? -b : b);
  endfunction
  assign ready_in  = (state_q == IDLE) || (state_q == OUT && ready_out);
  assign valid_out = state_q == OUT;
  assign blockOut  = pix_q;
  assign chOut     = chout_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    blk_d = blk_q;
    tmp_d = tmp_q;
    pix_d = pix_q;
    ch_d = ch_q;
    chout_d = chout_q;
    racc = '0;
    cacc = '0;
    cs = '0;
    accept = valid_in && ready_in;
    case (state_q)
      IDLE: state_d = accept ? ROW : IDLE;
      ROW: begin
        for (int x = 0; x < 8; x++) begin
          racc = '0;
          for (int u = 0; u < 8; u++) racc = racc + 28'(blk_q[cnt_q][u]) * 28'(cosv(x, u));
          tmp_d[cnt_q][x] = TMP_W'((racc + (28'sd1 <<< (RSH - 1))) >>> RSH);
        end
        cnt_d = cnt_q + 3'd1;
        state_d = cnt_q == 3'd7 ? COL : ROW;
      end
      COL: begin
        for (int y = 0; y < 8; y++) begin
          cacc = '0;
          for (int v = 0; v < 8; v++) cacc = cacc + 34'(tmp_q[v][cnt_q]) * 34'(cosv(y, v));
          cs = ((cacc + (34'sd1 <<< (CSH - 1))) >>> CSH) + 34'sd128;
          pix_d[y][cnt_q] = cs < 34'sd0 ? 8'd0 : (cs > 34'sd255 ? 8'd255 : cs[7:0]);
        end
        cnt_d = cnt_q + 3'd1;
        chout_d = cnt_q == 3'd7 ? ch_q : chout_q;
        state_d = cnt_q == 3'd7 ? OUT : COL;
      end
      default: state_d = ready_out ? (accept ? ROW : IDLE) : OUT;
    endcase
    if (accept) begin
      blk_d = blockIn;
      ch_d = chIn;
      cnt_d = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      blk_q <= '{default: '0};
      tmp_q <= '{default: '0};
      pix_q <= '{default: '0};
      ch_q <= '0;
      chout_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      blk_q <= blk_d;
      tmp_q <= tmp_d;
      pix_q <= pix_d;
      ch_q <= ch_d;
      chout_q <= chout_d;
    end
  end
endmodule
